serial_subtractor: RTL

Bit-serial, LSB-first two's-complement subtractor that computes `diff = a - b - bin` over `WIDTH` clock cycles using a single full-subtractor cell and a registered borrow. It is the inverse-direction companion of the parallel ripple-carry adder datapath. It trades latency for area, and presents a start/busy/done handshake so that a sequencer or datapath controller can issue operations to it.

---
 rtl/serial_subtractor_if.sv | 38 +++
 rtl/serial_subtractor.sv | 133 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for serial_subtractor.
// The zero/ovf signals exist only when SERIAL_SUBTRACTOR_FLAGS_EN is defined.
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    logic             zero;
    logic             ovf;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout, zero, ovf
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout, zero, ovf
    );
`else
    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
`endif
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: diff = a - b - bin over WIDTH cycles, start/busy/done handshake.
// Optional zero/ovf status flags are enabled by defining SERIAL_SUBTRACTOR_FLAGS_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input logic                clk,
    input logic                rst_n,
    serial_subtractor_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             brw_q, brw_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;

    logic x, y, r, d_bit, brw_nxt, accept;

    assign x       = a_sh_q[0];
    assign y       = b_sh_q[0];
    assign r       = brw_q;
    assign d_bit   = x ^ y ^ r;
    assign brw_nxt = (~x & y) | (~(x ^ y) & r);
    assign accept  = bus.start && (state_q != StShift);

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    // Operand sign bits are kept because the shift registers consume them.
    logic a_msb_q, a_msb_d;
    logic b_msb_q, b_msb_d;
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    state_d = StShift;
                    cnt_d   = '0;
                    a_sh_d  = bus.a;
                    b_sh_d  = bus.b;
                    brw_d   = bus.bin;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                // Result bits refill the minuend register from the top as it drains.
                a_sh_d = {d_bit, a_sh_q[WIDTH-1:1]};
                b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
                brw_d  = brw_nxt;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    diff_d  = {d_bit, a_sh_q[WIDTH-1:1]};
                    bout_d  = brw_nxt;
`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
                    zero_d  = ({d_bit, a_sh_q[WIDTH-1:1]} == '0);
                    ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
        end
    end

`ifdef SERIAL_SUBTRACTOR_FLAGS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.zero = zero_q;
    assign bus.ovf  = ovf_q;
`endif

    assign bus.busy = (state_q == StShift);
    assign bus.done = (state_q == StDone);
    assign bus.diff = diff_q;
    assign bus.bout = bout_q;
endmodule
